parity_arbiter: RTL and testbench

- Shares one 8-bit XOR parity accumulator among N_REQ requesters, one message at a time, using round-robin arbitration.
- Per granted message, the block clears the accumulator, streams exactly the requested number of bytes through it with a valid/ready handshake, then returns the final parity plus the requester ID.
- Sits between producer blocks (packet builders, memory scrubbers) and the single parity datapath.

---
 rtl/parity_arb_pkg.sv | 16 +
 rtl/parity_accum.sv | 24 ++
 rtl/parity_arbiter.sv | 168 ++++++++++++++++
 tb/tb_parity_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_arb_pkg.sv
// rtl/parity_arb_pkg.sv - shared state encoding and default widths for the parity arbiter
package parity_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FEED  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_TIMEOUT = 15;
    localparam int BYTE_W      = 8;

endpackage

// File: rtl/parity_accum.sv
// rtl/parity_accum.sv - 8-bit XOR parity accumulator with synchronous clear
module parity_accum
    import parity_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              ld,
    input  logic [BYTE_W-1:0] d,
    output logic [BYTE_W-1:0] parity
);

    // clr wins over ld so a new message never inherits a stale byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity <= '0;
        end else if (clr) begin
            parity <= '0;
        end else if (ld) begin
            parity <= parity ^ d;
        end
    end

endmodule

// File: rtl/parity_arbiter.sv
// rtl/parity_arbiter.sv - round-robin sharing of one parity accumulator; PARITY_ARB_TIMEOUT_EN adds a mid-message idle abort
module parity_arbiter
    import parity_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*LEN_W-1:0]  req_len,
    input  logic [N_REQ*BYTE_W-1:0] din,
    input  logic [N_REQ-1:0]        din_valid,
    output logic [N_REQ-1:0]        din_ready,
    output logic [N_REQ-1:0]        gnt,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [BYTE_W-1:0]       result,
    output logic                    err
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("parity_arbiter: unsupported N_REQ or TIMEOUT");
    end

    state_t             state;
    logic [ID_W-1:0]    gid;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    pick;
    logic               pick_ok;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   count;
    logic [BYTE_W-1:0]  byte_sel;
    logic [BYTE_W-1:0]  parity;
    logic               xfer;
    logic               clr;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // First requesting index at or above ptr, wrapping past N_REQ-1
    always_comb begin
        int              s;
        logic [ID_W-1:0] k;
        s       = 0;
        k       = '0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            s = int'(ptr) + i;
            if (s >= N_REQ) s = s - N_REQ;
            k = ID_W'(s);
            if (!pick_ok && req[k]) begin
                pick    = k;
                pick_ok = 1'b1;
            end
        end
    end

    assign byte_sel = din[gid*BYTE_W +: BYTE_W];
    assign xfer     = (state == FEED) && din_valid[gid] && din_ready[gid];
    assign clr      = (state == CLEAR);
    assign result   = parity;

    parity_accum u_accum (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .ld     (xfer),
        .d      (byte_sel),
        .parity (parity)
    );

`ifdef PARITY_ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            din_ready <= '0;
            done      <= 1'b0;
            done_id   <= '0;
            gid       <= '0;
            ptr       <= '0;
            len       <= '0;
            count     <= '0;
`ifdef PARITY_ARB_TIMEOUT_EN
            idle_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        gid   <= pick;
                        len   <= req_len[pick*LEN_W +: LEN_W];
                        gnt   <= onehot(pick);
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    count <= '0;
`ifdef PARITY_ARB_TIMEOUT_EN
                    idle_cnt <= '0;
                    err_q    <= 1'b0;
`endif
                    if (len == '0) begin
                        done    <= 1'b1;
                        done_id <= gid;
                        state   <= DONE;
                    end else begin
                        din_ready <= onehot(gid);
                        state     <= FEED;
                    end
                end
                FEED: begin
                    if (xfer) begin
                        count <= count + LEN_W'(1);
`ifdef PARITY_ARB_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if ((count + LEN_W'(1)) == len) begin
                            din_ready <= '0;
                            done      <= 1'b1;
                            done_id   <= gid;
                            state     <= DONE;
                        end
                    end
`ifdef PARITY_ARB_TIMEOUT_EN
                    else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                        din_ready <= '0;
                        done      <= 1'b1;
                        done_id   <= gid;
                        err_q     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
`endif
                end
                DONE: begin
                    gnt   <= '0;
                    ptr   <= (gid == ID_W'(N_REQ - 1)) ? '0 : gid + ID_W'(1);
                    state <= IDLE;
`ifdef PARITY_ARB_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_arbiter.sv
// tb/tb_parity_arbiter.sv - directed self-checking bench for parity_arbiter
module tb_parity_arbiter;

    localparam int N  = 4;
    localparam int LW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*LW-1:0]  req_len;
    logic [N*8-1:0]   din;
    logic [N-1:0]     din_valid;
    logic [N-1:0]     din_ready;
    logic [N-1:0]     gnt;
    logic             done;
    logic [1:0]       done_id;
    logic [7:0]       result;
    logic             err;

    always #5 clk = ~clk;

    parity_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_len   (req_len),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .gnt       (gnt),
        .done      (done),
        .done_id   (done_id),
        .result    (result),
        .err       (err)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source model: mode 0 always valid, 1 valid every other cycle, 2 constant 0xFF
    logic [7:0] src_byte [N][16];
    int         src_len  [N];
    int         src_idx  [N];
    int         src_mode [N];
    int         xfer_cnt [N];
    bit         phase;
    logic [N-1:0] ready_seen;

    int         dn;
    int         gcnt;
    logic [7:0] d_res [16];
    logic [1:0] d_id  [16];
    logic       d_err [16];
    int         d_lat [16];

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            if (src_mode[i] == 2) begin
                din_valid[i]   = 1'b1;
                din[i*8 +: 8]  = 8'hFF;
            end else if (src_idx[i] < src_len[i] && (src_mode[i] == 0 || phase)) begin
                din_valid[i]   = 1'b1;
                din[i*8 +: 8]  = src_byte[i][src_idx[i]];
            end else begin
                din_valid[i]   = 1'b0;
                din[i*8 +: 8]  = 8'h00;
            end
        end
    endtask

    task automatic cyc();
        logic [N-1:0] x;
        logic         done_now;
        logic [1:0]   id_now;
        @(negedge clk);
        x          = din_valid & din_ready;
        ready_seen = ready_seen | din_ready;
        if (gnt != '0) gcnt++; else gcnt = 0;
        done_now = done;
        id_now   = done_id;
        if (done && dn < 16) begin
            d_res[dn] = result;
            d_id[dn]  = done_id;
            d_err[dn] = err;
            d_lat[dn] = gcnt;
            dn++;
        end
        @(posedge clk);
        #1;
        phase = ~phase;
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                src_idx[i]++;
                xfer_cnt[i]++;
            end
        end
        if (done_now) src_idx[id_now] = 0;
        drive_src();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (dn < n && c < budget) begin
            cyc();
            c++;
        end
        check(tag, dn, n);
    endtask

    task automatic clear_model();
        dn         = 0;
        gcnt       = 0;
        phase      = 1'b0;
        ready_seen = '0;
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 0;
            src_idx[i]  = 0;
            src_mode[i] = 0;
            xfer_cnt[i] = 0;
        end
        drive_src();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        req_len = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        req_len = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt",       gnt,       0);
        check("rst_din_ready", din_ready, 0);
        check("rst_done",      done,      0);
        check("rst_done_id",   done_id,   0);
        check("rst_result",    result,    0);
        check("rst_err",       err,       0);
        reset = 1'b0;

        // Single requester; length changed after grant must be ignored
        src_len[0] = 3;
        src_byte[0][0] = 8'h0F; src_byte[0][1] = 8'hF0; src_byte[0][2] = 8'h55;
        req_len = 16'h0003;
        req     = 4'b0001;
        drive_src();
        cyc();
        req_len = 16'h000F;
        run_until(1, 20, "t1_done_seen");
        req = '0;
        check("t1_result",  d_res[0], 8'hAA);
        check("t1_done_id", d_id[0],  0);
        check("t1_err",     d_err[0], 0);
        check("t1_latency", d_lat[0], 5);
        repeat (3) cyc();
        check("t1_one_pulse", dn, 1);

        // Round-robin across four always-requesting sources
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_len[i]     = 1;
            src_byte[i][0] = 8'(i + 1);
        end
        req_len = 16'h1111;
        req     = 4'b1111;
        drive_src();
        run_until(5, 60, "rr_done_seen");
        req = '0;
        begin
            logic [1:0] exp_id  [5];
            logic [7:0] exp_res [5];
            exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
            exp_res = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01};
            for (int i = 0; i < 5; i++) begin
                check($sformatf("rr_id%0d", i),  d_id[i],  exp_id[i]);
                check($sformatf("rr_res%0d", i), d_res[i], exp_res[i]);
                check($sformatf("rr_lat%0d", i), d_lat[i], 3);
            end
        end

        // Zero length on requester 2
        do_reset();
        req_len = 16'h0000;
        req     = 4'b0100;
        run_until(1, 10, "zl_done_seen");
        req = '0;
        check("zl_result",   d_res[0], 8'h00);
        check("zl_done_id",  d_id[0],  2);
        check("zl_no_ready", ready_seen[2], 0);
        check("zl_latency",  d_lat[0], 2);

        // Back-pressure on requester 1, requester 3 pushing junk without request
        do_reset();
        src_mode[1] = 1;
        src_len[1]  = 4;
        src_byte[1][0] = 8'h01; src_byte[1][1] = 8'h02;
        src_byte[1][2] = 8'h04; src_byte[1][3] = 8'h08;
        src_mode[3] = 2;
        req_len = 16'h0040;
        req     = 4'b0010;
        drive_src();
        run_until(1, 40, "bp_done_seen");
        req = '0;
        check("bp_result",   d_res[0], 8'h0F);
        check("bp_done_id",  d_id[0],  1);
        check("bp_ready3",   ready_seen[3], 0);
        check("bp_xfer3",    xfer_cnt[3], 0);

        // Reset after two of four bytes, then a fresh one-byte message
        do_reset();
        src_len[0] = 4;
        src_byte[0][0] = 8'hA1; src_byte[0][1] = 8'hB2;
        src_byte[0][2] = 8'hC3; src_byte[0][3] = 8'hD4;
        req_len = 16'h0004;
        req     = 4'b0001;
        drive_src();
        begin
            int c;
            c = 0;
            while (xfer_cnt[0] < 2 && c < 20) begin
                cyc();
                c++;
            end
        end
        check("rm_two_bytes", xfer_cnt[0], 2);
        reset = 1'b1;
        req   = '0;
        #1;
        check("rm_gnt",       gnt,       0);
        check("rm_din_ready", din_ready, 0);
        check("rm_result",    result,    0);
        repeat (2) cyc();
        check("rm_no_done", dn, 0);
        reset = 1'b0;
        src_idx[0]     = 0;
        src_len[0]     = 1;
        src_byte[0][0] = 8'h3C;
        req_len = 16'h0001;
        req     = 4'b0001;
        drive_src();
        run_until(1, 10, "rm_done_seen");
        req = '0;
        check("rm_next_result", d_res[0], 8'h3C);
        check("rm_next_id",     d_id[0],  0);

`ifdef PARITY_ARB_TIMEOUT_EN
        // One byte of a three-byte message, then silence
        do_reset();
        src_len[0]     = 1;
        src_byte[0][0] = 8'h11;
        req_len = 16'h0003;
        req     = 4'b0001;
        drive_src();
        run_until(1, 40, "to_done_seen");
        req = '0;
        check("to_err",     d_err[0], 1);
        check("to_result",  d_res[0], 8'h11);
        check("to_latency", d_lat[0], 18);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
